// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  // Controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } sar_state_e;

  // Comparator verdict encodings for the {L,E,M} flag vector.
  localparam logic [2:0] ONE_HOT_L = 3'b100;
  localparam logic [2:0] ONE_HOT_E = 3'b010;
  localparam logic [2:0] ONE_HOT_M = 3'b001;

  // Midpoint of an inclusive range; the sum is one bit wider than the operands so it never wraps.
  function automatic logic [31:0] mid_of(input logic [31:0] lo, input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[32:1];
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: binary-searches 0..2^WIDTH-1 by
// driving a guess into a magnitude comparator and narrowing on its L/E/M verdict.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_M,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  // Range bounds carry one extra bit so guess+1 at the top of the range cannot wrap.
  localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   RANGE_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};

  sar_state_e       state_reg, state_next;
  logic [WIDTH:0]   lo_reg, lo_next;
  logic [WIDTH:0]   hi_reg, hi_next;
  logic [WIDTH-1:0] guess_reg, guess_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             done_reg, done_next;
  logic             found_reg, found_next;
  logic             error_reg, error_next;

  logic [2:0]       cmp_flags;
  logic [WIDTH:0]   lo_cand;
  logic [WIDTH:0]   hi_cand;

  assign cmp_flags = {cmp_L, cmp_E, cmp_M};
  assign lo_cand   = {1'b0, guess_reg} + RANGE_ONE;
  assign hi_cand   = {1'b0, guess_reg} - RANGE_ONE;

  // State register with synchronous active-low reset; a reset mid-search drops everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      lo_reg     <= '0;
      hi_reg     <= HI_INIT;
      guess_reg  <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      found_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lo_reg     <= lo_next;
      hi_reg     <= hi_next;
      guess_reg  <= guess_next;
      result_reg <= result_next;
      done_reg   <= done_next;
      found_reg  <= found_next;
      error_reg  <= error_next;
    end
  end

  // Next-state logic: accept start in IDLE, then narrow the range one probe per cycle.
  always_comb begin
    state_next  = state_reg;
    lo_next     = lo_reg;
    hi_next     = hi_reg;
    guess_next  = guess_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    found_next  = found_reg;
    error_next  = error_reg;

    case (state_reg)
      IDLE: begin
        // The done cycle is an IDLE cycle, but a start there is deliberately ignored.
        if (start && !done_reg) begin
          lo_next     = '0;
          hi_next     = HI_INIT;
          guess_next  = GUESS_INIT;
          found_next  = 1'b0;
          error_next  = 1'b0;
          result_next = '0;
          state_next  = PROBE;
        end
      end
      PROBE: begin
        case (cmp_flags)
          ONE_HOT_E: begin
            result_next = guess_reg;
            found_next  = 1'b1;
            done_next   = 1'b1;
            state_next  = IDLE;
          end
          ONE_HOT_L: begin
            if (lo_cand > hi_reg) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              lo_next    = lo_cand;
              guess_next = WIDTH'(mid_of(32'(lo_cand), 32'(hi_reg)));
            end
          end
          ONE_HOT_M: begin
            // guess=0 would push hi below zero: the range is already empty.
            if (guess_reg == '0 || lo_reg > hi_cand) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              hi_next    = hi_cand;
              guess_next = WIDTH'(mid_of(32'(lo_reg), 32'(hi_cand)));
            end
          end
          default: begin
            // No flag or several flags: the comparator cannot be trusted.
            error_next = 1'b1;
            found_next = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  assign guess  = guess_reg;
  assign busy   = (state_reg == PROBE);
  assign done   = done_reg;
  assign found  = found_reg;
  assign error  = error_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: a behavioural comparator (with fault injection) sits between
// guess and target; expected guess sequences are queued and popped as probes occur.
module tb_sar_search_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] guess;
  logic             cmp_L, cmp_E, cmp_M;
  logic             busy, done, found, error;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] target = '0;
  int               fault_mode = 0;  // 0 normal, 1 L&M on probe 2, 2 no flags on probe 2, 3 always M
  int               probe_idx = 0;

  int checks = 0;
  int failures = 0;
  int exp_guess_q[$];

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .guess  (guess),
    .cmp_L  (cmp_L),
    .cmp_E  (cmp_E),
    .cmp_M  (cmp_M),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .error  (error),
    .result (result)
  );

  always #5 clk = ~clk;

  // Probe counter: zero during the first probe cycle of a search.
  always @(posedge clk) begin
    if (!busy) probe_idx <= 0;
    else       probe_idx <= probe_idx + 1;
  end

  // Comparator model with optional faults.
  always_comb begin
    cmp_L = (guess < target);
    cmp_E = (guess == target);
    cmp_M = (guess > target);
    if (fault_mode == 1 && probe_idx == 1) begin
      cmp_L = 1'b1; cmp_E = 1'b0; cmp_M = 1'b1;
    end else if (fault_mode == 2 && probe_idx == 1) begin
      cmp_L = 1'b0; cmp_E = 1'b0; cmp_M = 1'b0;
    end else if (fault_mode == 3) begin
      cmp_L = 1'b0; cmp_E = 1'b0; cmp_M = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one search; expected guesses must already be queued. Latency is counted
  // in cycles from the cycle start is presented to the cycle done is high.
  task automatic run_search(input string name, input int tgt, input int fm,
                            input int exp_found, input int exp_err, input int exp_res,
                            input int exp_lat, input int pulse_at, input bit start_in_done);
    int lat;
    int g;
    target = tgt[WIDTH-1:0];
    fault_mode = fm;
    @(negedge clk); start = 1'b1; lat = 0;
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      check_eq({name, ".busy"}, int'(busy), 1);
      if (exp_guess_q.size() > 0) begin
        g = exp_guess_q.pop_front();
        check_eq({name, ".guess"}, int'(guess), g);
      end else begin
        check_eq({name, ".extra_probe"}, int'(guess), -1);
      end
      start = (pulse_at != 0 && lat == pulse_at);
      @(negedge clk); lat++;
    end
    start = 1'b0;
    check_eq({name, ".done_seen"}, int'(done), 1);
    check_eq({name, ".latency"}, lat, exp_lat);
    check_eq({name, ".busy_in_done"}, int'(busy), 0);
    check_eq({name, ".found"}, int'(found), exp_found);
    check_eq({name, ".error"}, int'(error), exp_err);
    check_eq({name, ".result"}, int'(result), exp_res);
    check_eq({name, ".guesses_left"}, exp_guess_q.size(), 0);
    exp_guess_q.delete();
    $display("search %s target=%0d fault=%0d found=%0d error=%0d result=%0d latency=%0d",
             name, tgt, fm, found, error, result, lat);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, ".done_pulse_end"}, int'(done), 0);
    check_eq({name, ".idle_after"}, int'(busy), 0);
    check_eq({name, ".found_held"}, int'(found), exp_found);
    check_eq({name, ".result_held"}, int'(result), exp_res);
    fault_mode = 0;
  endtask

  initial begin
    int lo, hi, g, n;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst.guess", int'(guess), 0);
    check_eq("rst.busy", int'(busy), 0);
    check_eq("rst.done", int'(done), 0);
    check_eq("rst.found", int'(found), 0);
    check_eq("rst.error", int'(error), 0);
    check_eq("rst.result", int'(result), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed searches.
    exp_guess_q = '{7, 11};
    run_search("t11", 11, 0, 1, 0, 11, 3, 0, 1'b0);
    exp_guess_q = '{7, 3, 1, 0};
    run_search("t0", 0, 0, 1, 0, 0, 5, 0, 1'b0);
    exp_guess_q = '{7, 11, 13, 14, 15};
    run_search("t15", 15, 0, 1, 0, 15, 6, 0, 1'b0);

    // Faulty comparator verdicts.
    exp_guess_q = '{7, 11};
    run_search("both_lm", 11, 1, 0, 1, 0, 3, 0, 1'b0);
    exp_guess_q = '{7, 11};
    run_search("no_flags", 11, 2, 0, 1, 0, 3, 0, 1'b0);
    exp_guess_q = '{7, 3, 1, 0};
    run_search("always_m", 5, 3, 0, 0, 0, 5, 0, 1'b0);

    // Start while busy and in the done cycle must both be ignored.
    exp_guess_q = '{7, 11, 13, 14, 15};
    run_search("start_ignored", 15, 0, 1, 0, 15, 6, 2, 1'b1);

    // Reset during the second probe aborts with every output cleared.
    target = 15;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("abort.probe1_guess", int'(guess), 7);
    @(negedge clk);
    check_eq("abort.probe2_guess", int'(guess), 11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort.guess", int'(guess), 0);
    check_eq("abort.busy", int'(busy), 0);
    check_eq("abort.done", int'(done), 0);
    check_eq("abort.found", int'(found), 0);
    check_eq("abort.error", int'(error), 0);
    check_eq("abort.result", int'(result), 0);
    $display("abort reset during probe 2 busy=%0d done=%0d guess=%0d", busy, done, guess);
    @(negedge clk);
    check_eq("abort.no_done", int'(done), 0);
    exp_guess_q = '{7, 11, 13};
    run_search("after_abort", 13, 0, 1, 0, 13, 4, 0, 1'b0);

    // Every target, expectations from an integer binary-search reference.
    for (int t = 0; t < (1 << WIDTH); t++) begin
      lo = 0; hi = (1 << WIDTH) - 1; n = 0;
      forever begin
        g = (lo + hi) / 2;
        exp_guess_q.push_back(g);
        n++;
        if (g == t) break;
        if (g < t) lo = g + 1;
        else       hi = g - 1;
      end
      run_search($sformatf("sweep%0d", t), t, 0, 1, 0, t, n + 1, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
